// File: rtl/branch_predict_unit.sv
// branch_predict_unit: resolves RISC-V branches/jumps from NZCV flags, predicts with a
// PC-indexed table of 2-bit saturating counters and keeps saturating branch/mispredict stats.
module branch_predict_unit #(
    parameter int ENTRIES = 64,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [31:0]       res_instr,
    input  logic [31:0]       res_pc,
    input  logic [3:0]        res_aluflags,
    input  logic              res_pred,
    output logic              out_valid,
    output logic              taken,
    output logic              mispredict,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]       ctr [ENTRIES];
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             n, z, c, v;
    logic             is_br, is_jmp, base, cond, res_taken, miss;
    logic [IDX_W-1:0] res_idx;
    logic [1:0]       cur;
    logic             unused_bits;

    always_comb begin
        opcode       = res_instr[6:0];
        funct3       = res_instr[14:12];
        {n, z, c, v} = res_aluflags;
        is_br        = opcode == 7'b1100011;
        is_jmp       = opcode == 7'b1101111 || opcode == 7'b1100111;
        // funct3[0] inverts the base condition; funct3 01x encodes no branch
        base         = funct3[2:1] == 2'b00 ? z : funct3[2:1] == 2'b10 ? n ^ v : !c;
        cond         = funct3[2:1] == 2'b01 ? 1'b0 : base ^ funct3[0];
        res_taken    = is_jmp | (is_br & cond);
        miss         = res_taken != res_pred;
        res_idx      = res_pc[IDX_W+1:2];
        cur          = ctr[res_idx];
    end

    assign pred_taken  = ctr[pred_pc[IDX_W+1:2]][1];
    assign unused_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], res_pc[31:IDX_W+2], res_pc[1:0],
                           res_instr[31:15], res_instr[11:7]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
            out_valid        <= 1'b0;
            taken            <= 1'b0;
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            out_valid        <= res_valid;
            taken            <= res_valid & res_taken;
            mispredict       <= res_valid & miss;
            branch_count     <= branch_count + STAT_W'(res_valid && (is_br || is_jmp) && !(&branch_count));
            mispredict_count <= mispredict_count + STAT_W'(res_valid && miss && !(&mispredict_count));
            if (res_valid && is_br)
                ctr[res_idx] <= res_taken ? (cur == 2'b11 ? cur : cur + 2'd1)
                                          : (cur == 2'b00 ? cur : cur - 2'd1);
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed and randomized checks of branch_predict_unit against a
// behavioural model (operand comparisons, integer counter array, saturating integer stats).
module tb_branch_predict_unit;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    logic        clk, reset, res_valid, res_pred;
    logic [31:0] pred_pc, res_instr, res_pc;
    logic [3:0]  res_aluflags;
    logic        pt, ov, tk, mp, pt4, ov4, tk4, mp4;
    logic [15:0] bc, mc;
    logic [3:0]  bc4, mc4;

    int tbl [64];
    int e_bc, e_mc, e_bc4, e_mc4;
    bit e_ov, e_tk, e_mp, tbl_known;
    int vectors, miscompares;

    branch_predict_unit #(.ENTRIES(64), .STAT_W(16)) dut (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(pt),
        .res_valid(res_valid), .res_instr(res_instr), .res_pc(res_pc),
        .res_aluflags(res_aluflags), .res_pred(res_pred), .out_valid(ov), .taken(tk),
        .mispredict(mp), .branch_count(bc), .mispredict_count(mc));

    branch_predict_unit #(.ENTRIES(64), .STAT_W(4)) dut4 (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(pt4),
        .res_valid(res_valid), .res_instr(res_instr), .res_pc(res_pc),
        .res_aluflags(res_aluflags), .res_pred(res_pred), .out_valid(ov4), .taken(tk4),
        .mispredict(mp4), .branch_count(bc4), .mispredict_count(mc4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom;
        r[6:0] = op;
        r[14:12] = f3;
        return r;
    endfunction

    // One clock: drive, check the pre-edge prediction, advance the model, check the results.
    task automatic cycle(input bit rst, input bit v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [3:0] fl, input bit pr, input bit etk);
        bit br, jmp;
        int i;
        reset = rst; res_valid = v; res_instr = instr; res_pc = pc; res_aluflags = fl; res_pred = pr;
        #1;
        if (tbl_known) begin
            chk("pred_taken", pt, tbl[pred_pc[7:2]] >= 2);
            chk("pred_taken4", pt4, tbl[pred_pc[7:2]] >= 2);
        end
        @(posedge clk);
        br  = instr[6:0] == OP_BR;
        jmp = instr[6:0] == OP_JAL || instr[6:0] == OP_JALR;
        if (rst) begin
            foreach (tbl[k]) tbl[k] = 1;
            tbl_known = 1;
            {e_ov, e_tk, e_mp} = 3'b000;
            e_bc = 0; e_mc = 0; e_bc4 = 0; e_mc4 = 0;
        end else begin
            e_ov = v;
            e_tk = v && etk;
            e_mp = v && (etk != pr);
            if (v && (br || jmp)) begin
                e_bc = e_bc < 65535 ? e_bc + 1 : e_bc;
                e_bc4 = e_bc4 < 15 ? e_bc4 + 1 : e_bc4;
            end
            if (e_mp) begin
                e_mc = e_mc < 65535 ? e_mc + 1 : e_mc;
                e_mc4 = e_mc4 < 15 ? e_mc4 + 1 : e_mc4;
            end
            if (v && br) begin
                i = pc[7:2];
                tbl[i] = etk ? (tbl[i] < 3 ? tbl[i] + 1 : 3) : (tbl[i] > 0 ? tbl[i] - 1 : 0);
            end
        end
        @(negedge clk);
        chk("out_valid", ov, e_ov);
        chk("taken", tk, e_tk);
        chk("mispredict", mp, e_mp);
        chk("branch_count", bc, e_bc);
        chk("mispredict_count", mc, e_mc);
        chk("out_valid4", ov4, e_ov);
        chk("branch_count4", bc4, e_bc4);
        chk("mispredict_count4", mc4, e_mc4);
    endtask

    task automatic sweep_zero();
        for (int a = 0; a < 64; a++) begin
            pred_pc = 32'(a * 4);
            #1;
            chk("sweep", pt, 1'b0);
            chk("sweep4", pt4, 1'b0);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 0, 32'h13, 0, 4'b0000, 0, 0);
    endtask

    initial begin
        logic [31:0] a, b, d, ins, pc;
        logic [3:0]  fl;
        logic [2:0]  f3;
        logic [6:0]  others [5];
        bit          etk;
        int          kind;
        others = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111};
        vectors = 0; miscompares = 0; tbl_known = 0;
        reset = 1; res_valid = 0; res_instr = 0; res_pc = 0; res_aluflags = 0; res_pred = 0; pred_pc = 0;
        @(negedge clk);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        sweep_zero();
        idle();

        pred_pc = 32'h40;
        cycle(0, 1, mk(OP_BR, 3'b000), 32'h40, 4'b0100, 0, 1);
        chk("beq_pred_after", pt, 1'b1);
        idle();

        pred_pc = 32'h0;
        cycle(0, 1, mk(OP_BR, 3'b001), 32'h80, 4'b0000, 0, 1);
        cycle(0, 1, mk(OP_BR, 3'b100), 32'h80, 4'b1000, 0, 1);
        cycle(0, 1, mk(OP_BR, 3'b101), 32'h80, 4'b1001, 0, 1);
        cycle(0, 1, mk(OP_BR, 3'b110), 32'h80, 4'b0010, 0, 0);
        cycle(0, 1, mk(OP_BR, 3'b111), 32'h80, 4'b1010, 0, 1);
        cycle(0, 1, mk(OP_BR, 3'b010), 32'h80, 4'b0100, 0, 0);
        cycle(0, 1, mk(7'b0110011, 3'b000), 32'h80, 4'b0100, 0, 0);

        pred_pc = 32'h40;
        repeat (3) cycle(0, 1, mk(OP_BR, 3'b000), 32'h40, 4'b0100, 1, 1);
        repeat (4) cycle(0, 1, mk(OP_BR, 3'b000), 32'h40, 4'b0000, 1, 0);
        idle();
        chk("sat_low_pred", pt, 1'b0);

        repeat (2) cycle(0, 1, mk(OP_BR, 3'b000), 32'h140, 4'b0100, 0, 1);
        idle();
        chk("alias_pred", pt, 1'b1);
        cycle(0, 1, mk(OP_JAL, 3'b000), 32'h40, 4'b0000, 1, 1);
        cycle(0, 1, mk(OP_JALR, 3'b000), 32'h40, 4'b0000, 1, 1);
        cycle(0, 1, mk(7'b0010011, 3'b000), 32'h40, 4'b0100, 1, 0);
        idle();

        cycle(1, 1, mk(OP_BR, 3'b000), 32'h40, 4'b0100, 0, 1);
        sweep_zero();
        pred_pc = 32'h40;
        repeat (20) cycle(0, 1, mk(OP_BR, 3'b001), 32'h40, 4'b0000, 0, 1);
        chk("bc4_sat", bc4, 4'd15);
        chk("mc4_sat", mc4, 4'd15);
        chk("bc16_20", bc, 16'd20);

        for (int it = 0; it < 400; it++) begin
            a = $urandom;
            b = $urandom_range(0, 3) == 0 ? a : $urandom;
            d = a - b;
            fl = {d[31], d == 0, a >= b, (a[31] != b[31]) && (d[31] != a[31])};
            f3 = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 9);
            if (kind == 6 || kind == 7) begin
                ins = mk(kind == 6 ? OP_JAL : OP_JALR, f3);
                etk = 1;
            end else if (kind == 8) begin
                ins = mk(others[$urandom_range(0, 4)], f3);
                etk = 0;
            end else begin
                ins = mk(OP_BR, f3);
                etk = f3 == 3'b000 ? a == b :
                      f3 == 3'b001 ? a != b :
                      f3 == 3'b100 ? $signed(a) < $signed(b) :
                      f3 == 3'b101 ? $signed(a) >= $signed(b) :
                      f3 == 3'b110 ? a < b :
                      f3 == 3'b111 ? a >= b : 1'b0;
            end
            pc = 32'($urandom_range(0, 127) * 4);
            pred_pc = 32'($urandom_range(0, 127) * 4);
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, ins, pc, fl,
                  1'($urandom_range(0, 1)), etk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the combinational branch checker. It resolves RISC-V conditional branches and jumps from the instruction word and the ALU NZCV flags, as the checker did. It adds a PC-indexed table of 2-bit saturating counters, registered resolve outputs, mispredict detection against the fetch-time prediction, and saturating performance counters. It sits between the execute stage (resolve port) and the fetch stage (predict port).

## Interface
- ENTRIES, 64, number of predictor counters; power of two, ≥2; IDX_W = $clog2(ENTRIES)
- STAT_W, 16, width of each statistics counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pred_pc  in  32  fetch PC to predict
- pred_taken  out  1  MSB of counter at index pred_pc[IDX_W+1:2]; combinational from table state
- res_valid  in  1  resolve request this cycle
- res_instr  in  32  instruction being resolved
- res_pc  in  32  PC of res_instr
- res_aluflags  in  4  {N,Z,C,V} from rs1−rs2 (C=1 means no borrow)
- res_pred  in  1  prediction fetch used for this instruction
- out_valid  out  1  registered; pulses one cycle per accepted resolve
- taken  out  1  registered resolved direction
- mispredict  out  1  registered; taken != res_pred
- branch_count  out  STAT_W  resolved control-flow instructions, saturating
- mispredict_count  out  STAT_W  mispredicts, saturating

## Operation
- Decode uses opcode = res_instr[6:0] and funct3 = res_instr[14:12].
- Opcode 1100011 (branch): BEQ 000 → Z; BNE 001 → !Z; BLT 100 → N^V; BGE 101 → !(N^V); BLTU 110 → !C; BGEU 111 → C; funct3 010/011 → 0.
- Opcode 1101111 (JAL) or 1100111 (JALR) → taken=1 regardless of flags.
- Any other opcode → taken=0. Mispredict is still evaluated.
- Counter update happens only for opcode 1100011 with res_valid. idx = res_pc[IDX_W+1:2]. Taken → increment, saturating at 11. Not taken → decrement, saturating at 00.
- JAL/JALR and non-control opcodes never modify the table.
- Aliasing is allowed: PCs differing only above bit IDX_W+1 share a counter.
- branch_count += 1 on res_valid with branch/JAL/JALR opcode. mispredict_count += 1 on res_valid with taken != res_pred. Both saturate at all-ones and never wrap.
- Reset: every table counter = 01 (weakly not-taken). out_valid, taken, mispredict = 0. Both stats = 0. pred_taken therefore reads 0 after reset.

## Timing
- Resolve latency is 1 cycle. Inputs sampled at edge k drive out_valid/taken/mispredict valid after edge k; they hold until edge k+1.
- out_valid=0 in any cycle following a cycle with res_valid=0. taken and mispredict are forced to 0 when out_valid=0.
- Stats update on the same edge as out_valid. The new value is visible together with out_valid=1.
- Counter write happens at edge k. pred_pc lookup of the same index in cycle k returns the pre-update value (read-before-write); the new value is visible from cycle k+1.
- Back-to-back res_valid every cycle is supported with no stall. Consecutive updates to one index accumulate correctly.
- reset has priority over res_valid in the same cycle: no table or stats update, and outputs are 0 after that edge.
- Reset asserted mid-stream discards the in-flight result. out_valid is 0 the cycle after reset.

## Test plan
- Reset, then sweep pred_pc 0x0..0xFC → pred_taken=0 everywhere; out_valid=0, branch_count=0, mispredict_count=0.
- Resolve BEQ at res_pc=0x40, flags 0100, res_pred=0 → next cycle out_valid=1, taken=1, mispredict=1, both counts=1. Same cycle pred_pc=0x40 → 0; next cycle → 1 (idx16 counter 01→10).
- Condition sweep, all with res_pred=0 → taken values:
  - BNE flags 0000 → 1
  - BLT 1000 → 1
  - BGE 1001 → 1
  - BLTU 0010 → 0
  - BGEU 1010 → 1
  - funct3 010 → 0
  - opcode 0110011 → 0
- Saturation at 0x40 (state 10): 3 taken BEQs → counter 11, pred 1. 1 not-taken → 10, pred 1. 2 not-taken → 00, pred 0. 1 more not-taken → stays 00.
- Aliasing and jumps:
  - Taken BEQ at 0x140 (ENTRIES=64) moves the idx16 counter that pred_pc=0x40 reads.
  - JAL with res_pred=1 → taken=1, mispredict=0, table unchanged, branch_count+1.
  - Non-branch opcode with res_pred=1 → mispredict=1, branch_count unchanged.
- Reset and saturation:
  - reset and res_valid in the same cycle → next cycle out_valid=0, stats 0, table all 01.
  - With STAT_W=4: 20 mispredicted BNEs back-to-back → both counts hold at 15.
